// File: rtl/video_pixseq.sv
// Pixel sequencer: double-buffers fetched 32-bit video words (cur/nxt) and
// steps the pixel selector at pixel rate for the renderer.
module video_pixseq #(
    parameter logic [3:0] RST_PSEL = 4'h0
) (
    input  logic        clk,
    input  logic        res,
    input  logic        c1,
    input  logic        line_start,
    input  logic        gfx_act,
    input  logic [1:0]  render_mode,
    input  logic        hires,
    input  logic [3:0]  fine_x,
    input  logic [31:0] fb_data,
    input  logic        fb_valid,
    output logic        fb_pop,
    output logic [31:0] data,
    output logic [3:0]  psel,
    output logic        underrun,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [1:0]  r_mode;
    logic        r_hires;
    logic [31:0] r_cur;
    logic        r_curV;
    logic [31:0] r_nxt;
    logic        r_nxtV;
    logic [3:0]  r_psel;
    logic        r_underrun;
    logic        r_gfxD;

    logic        w_pop;
    logic        w_primeUnderrun;
    logic        w_pixEn;
    logic        w_fall;
    logic        w_step;
    logic        w_last;
    logic [3:0]  w_mask;
    logic [3:0]  w_startPsel;

    // Last-pixel index of a word (pixels per word minus one) for a render mode.
    function automatic logic [3:0] ppwMask(input logic [1:0] mode);
        case (mode)
            2'd1:    ppwMask = 4'h3;
            2'd2:    ppwMask = 4'h1;
            default: ppwMask = 4'hF;
        endcase
    endfunction

    assign w_mask      = ppwMask(r_mode);
    assign w_startPsel = fine_x & ppwMask(render_mode);
    assign w_pixEn     = r_hires | c1;
    assign w_fall      = r_gfxD & ~gfx_act;
    assign w_step      = (r_state == RUN) & gfx_act & w_pixEn;
    assign w_last      = (r_psel == w_mask);

    // Next-state and pop decision; line_start and then res override everything.
    always_comb begin
        w_nextState     = r_state;
        w_pop           = 1'b0;
        w_primeUnderrun = 1'b0;
        case (r_state)
            IDLE: begin
                if (line_start) begin
                    w_nextState = PRIME;
                end
            end
            PRIME: begin
                w_pop = fb_valid;
                if (r_curV && fb_valid) begin
                    w_nextState = RUN;
                end else if (gfx_act) begin
                    w_nextState     = RUN;
                    w_primeUnderrun = 1'b1;
                end
            end
            RUN: begin
                if (w_fall) begin
                    w_nextState = IDLE;
                end else begin
                    w_pop = ~r_nxtV & fb_valid;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if (line_start) begin
            w_nextState     = PRIME;
            w_pop           = 1'b0;
            w_primeUnderrun = 1'b0;
        end
        if (res) begin
            w_nextState     = IDLE;
            w_pop           = 1'b0;
            w_primeUnderrun = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Word buffers, pixel selector, latched line config and sticky underrun.
    always_ff @(posedge clk) begin
        if (res) begin
            r_mode     <= 2'd0;
            r_hires    <= 1'b0;
            r_cur      <= 32'h0;
            r_curV     <= 1'b0;
            r_nxt      <= 32'h0;
            r_nxtV     <= 1'b0;
            r_psel     <= RST_PSEL;
            r_underrun <= 1'b0;
            r_gfxD     <= 1'b0;
        end else begin
            r_gfxD <= gfx_act;
            if (line_start) begin
                r_mode     <= render_mode;
                r_hires    <= hires;
                r_psel     <= w_startPsel;
                r_cur      <= 32'h0;
                r_curV     <= 1'b0;
                r_nxt      <= 32'h0;
                r_nxtV     <= 1'b0;
                r_underrun <= 1'b0;
            end else begin
                case (r_state)
                    PRIME: begin
                        if (w_pop) begin
                            if (!r_curV) begin
                                r_cur  <= fb_data;
                                r_curV <= 1'b1;
                            end else begin
                                r_nxt  <= fb_data;
                                r_nxtV <= 1'b1;
                            end
                        end
                        if (w_primeUnderrun) begin
                            r_underrun <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (w_step) begin
                            if (w_last) begin
                                r_psel <= 4'h0;
                                r_cur  <= r_nxtV ? r_nxt : 32'h0;
                                r_nxtV <= 1'b0;
                                if (!r_nxtV) begin
                                    r_underrun <= 1'b1;
                                end
                            end else begin
                                r_psel <= r_psel + 4'd1;
                            end
                        end
                        if (w_pop) begin
                            r_nxt  <= fb_data;
                            r_nxtV <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign fb_pop   = w_pop;
    assign data     = r_cur;
    assign psel     = r_psel;
    assign underrun = r_underrun;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_video_pixseq.sv
// Testbench for video_pixseq: fetch-buffer model, pixel scoreboard, directed lines.
module tb_video_pixseq;

    logic        clk = 1'b0;
    logic        res;
    logic        c1;
    logic        line_start;
    logic        gfx_act;
    logic [1:0]  render_mode;
    logic        hires;
    logic [3:0]  fine_x;
    logic [31:0] fb_data;
    logic        fb_valid;
    logic        fb_pop;
    logic [31:0] data;
    logic [3:0]  psel;
    logic        underrun;
    logic        busy;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  p;
    } pix_t;

    pix_t        pixQ[$];
    logic [31:0] bufQ[$];
    logic [31:0] lineWords[16];
    int          checkCount = 0;
    int          passCount  = 0;
    int          popCount   = 0;
    bit          popPending = 0;
    bit          qualPrev   = 0;
    bit          stall      = 0;
    bit          curHires   = 0;

    video_pixseq #(.RST_PSEL(4'h0)) dut (
        .clk        (clk),
        .res        (res),
        .c1         (c1),
        .line_start (line_start),
        .gfx_act    (gfx_act),
        .render_mode(render_mode),
        .hires      (hires),
        .fine_x     (fine_x),
        .fb_data    (fb_data),
        .fb_valid   (fb_valid),
        .fb_pop     (fb_pop),
        .data       (data),
        .psel       (psel),
        .underrun   (underrun),
        .busy       (busy)
    );

    // Free-running system clock.
    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    endtask

    // Fetch buffer head presentation.
    task automatic driveBuf();
        fb_valid = (bufQ.size() != 0) && !stall;
        fb_data  = (bufQ.size() != 0) ? bufQ[0] : 32'h0;
    endtask

    // One clock: consume a popped word, advance the c1 phase.
    task automatic tick();
        @(posedge clk);
        #1;
        if (popPending && bufQ.size() != 0) void'(bufQ.pop_front());
        popPending = 0;
        c1 = ~c1;
        driveBuf();
    endtask

    task automatic loadBuf(input int n);
        bufQ.delete();
        for (int i = 0; i < n; i++) bufQ.push_back(lineWords[i]);
        driveBuf();
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic hi, input logic [3:0] fx);
        line_start  = 1'b1;
        gfx_act     = 1'b0;
        render_mode = mode;
        hires       = hi;
        fine_x      = fx;
        curHires    = hi;
        popCount    = 0;
        #1;
        checkOutput("popOnLineStart", {31'h0, fb_pop}, 32'h0);
        tick();
        line_start = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // Expected pixel stream for n qualifying pixel steps from a start psel.
    task automatic expectRun(input int start, input int ppw, input int n);
        pix_t e;
        for (int k = 1; k <= n; k++) begin
            e.d = lineWords[(start + k) / ppw];
            e.p = 4'((start + k) % ppw);
            pixQ.push_back(e);
        end
    endtask

    task automatic pushPix(input logic [31:0] d, input logic [3:0] p);
        pix_t e;
        e.d = d;
        e.p = p;
        pixQ.push_back(e);
    endtask

    task automatic runPixels(input int cycles, input int stallFrom, input int stallTo);
        while (c1 != 1'b1) tick();
        for (int c = 1; c <= cycles; c++) begin
            gfx_act = 1'b1;
            stall   = (c >= stallFrom) && (c <= stallTo);
            driveBuf();
            tick();
        end
        stall = 0;
        driveBuf();
    endtask

    task automatic endLine();
        gfx_act = 1'b0;
        tick();
        tick();
        #1;
    endtask

    // Monitor: compares each rendered pixel against the scoreboard and polices pops.
    always @(negedge clk) begin
        pix_t e;
        if (qualPrev) begin
            if (pixQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL extraPixel: got data 0x%08h psel %0d with no expected pixel", data, psel);
            end else begin
                e = pixQ.pop_front();
                checkOutput("pixData", data, e.d);
                checkOutput("pixPsel", {28'h0, psel}, {28'h0, e.p});
            end
        end
        if (fb_pop) begin
            popCount++;
            checkOutput("popLegal", {31'h0, fb_valid & ~res & ~line_start}, 32'h1);
        end
        popPending = fb_pop;
        qualPrev   = (curHires || c1) && gfx_act && busy && !res && !line_start;
    end

    initial begin
        res = 1'b1; c1 = 1'b0; line_start = 1'b0; gfx_act = 1'b0;
        render_mode = 2'd0; hires = 1'b0; fine_x = 4'h0;
        bufQ.delete();
        driveBuf();
        tick();
        tick();
        #1;
        checkOutput("rstPsel", {28'h0, psel}, 32'h0);
        checkOutput("rstData", data, 32'h0);
        checkOutput("rstBusy", {31'h0, busy}, 32'h0);
        checkOutput("rstUnderrun", {31'h0, underrun}, 32'h0);
        checkOutput("rstPop", {31'h0, fb_pop}, 32'h0);
        res = 1'b0;
        tick();

        // ZX, fine 0: swap after 16 pixels, refill right after.
        lineWords[0] = 32'hA; lineWords[1] = 32'hB; lineWords[2] = 32'hC;
        loadBuf(3);
        applyStimulus(2'd0, 1'b0, 4'h0);
        checkOutput("zxPrimeData", data, 32'hA);
        checkOutput("zxPrimePsel", {28'h0, psel}, 32'h0);
        checkOutput("zxBusy", {31'h0, busy}, 32'h1);
        checkOutput("zxPrimePops", popCount, 2);
        expectRun(0, 16, 20);
        runPixels(40, 0, 0);
        endLine();
        checkOutput("zxPops", popCount, 3);
        checkOutput("zxUnderrun", {31'h0, underrun}, 32'h0);
        checkOutput("zxIdle", {31'h0, busy}, 32'h0);

        // 16c, fine 6: start psel 2.
        for (int i = 0; i < 4; i++) lineWords[i] = 32'hD000_0000 + i;
        loadBuf(4);
        applyStimulus(2'd1, 1'b0, 4'h6);
        checkOutput("c16StartPsel", {28'h0, psel}, 32'h2);
        checkOutput("c16StartData", data, 32'hD000_0000);
        expectRun(2, 4, 10);
        runPixels(20, 0, 0);
        endLine();
        checkOutput("c16Pops", popCount, 4);
        checkOutput("c16Underrun", {31'h0, underrun}, 32'h0);

        // 256c hires, fine 3: pixel every clk, start psel 1.
        for (int i = 0; i < 12; i++) lineWords[i] = 32'h2560_0000 + i;
        loadBuf(12);
        applyStimulus(2'd2, 1'b1, 4'h3);
        checkOutput("hiStartPsel", {28'h0, psel}, 32'h1);
        expectRun(1, 2, 14);
        runPixels(14, 0, 0);
        endLine();
        checkOutput("hiPops", popCount, 9);
        checkOutput("hiUnderrun", {31'h0, underrun}, 32'h0);

        // 256c with the buffer stalled for 6 clk: underrun and a zero word.
        for (int i = 0; i < 8; i++) lineWords[i] = 32'h4444_0000 + i;
        loadBuf(8);
        applyStimulus(2'd2, 1'b0, 4'h0);
        pushPix(32'h4444_0000, 4'd1);
        pushPix(32'h4444_0001, 4'd0);
        pushPix(32'h4444_0001, 4'd1);
        pushPix(32'h0000_0000, 4'd0);
        pushPix(32'h0000_0000, 4'd1);
        pushPix(32'h4444_0002, 4'd0);
        pushPix(32'h4444_0002, 4'd1);
        pushPix(32'h4444_0003, 4'd0);
        curHires = 1'b0;
        runPixels(16, 4, 9);
        endLine();
        checkOutput("urUnderrun", {31'h0, underrun}, 32'h1);
        checkOutput("urPops", popCount, 5);

        // ZX line interrupted by line_start with nxt loaded; fresh 16c line.
        for (int i = 0; i < 4; i++) lineWords[i] = 32'h5A00_0000 + i;
        loadBuf(4);
        applyStimulus(2'd0, 1'b0, 4'h0);
        checkOutput("lsUnderrunCleared", {31'h0, underrun}, 32'h0);
        expectRun(0, 16, 4);
        runPixels(8, 0, 0);
        for (int i = 0; i < 3; i++) lineWords[i] = 32'hE000_0000 + i;
        loadBuf(3);
        applyStimulus(2'd1, 1'b0, 4'h5);
        checkOutput("lsData", data, 32'hE000_0000);
        checkOutput("lsPsel", {28'h0, psel}, 32'h1);
        checkOutput("lsPrimePops", popCount, 2);
        expectRun(1, 4, 6);
        runPixels(12, 0, 0);
        endLine();
        checkOutput("lsPops", popCount, 3);

        // res mid-RUN with line_start and a valid buffer head.
        for (int i = 0; i < 4; i++) lineWords[i] = 32'hF000_0000 + i;
        loadBuf(4);
        applyStimulus(2'd0, 1'b0, 4'h0);
        expectRun(0, 16, 5);
        runPixels(10, 0, 0);
        res = 1'b1;
        line_start = 1'b1;
        #1;
        checkOutput("resPopSame", {31'h0, fb_pop}, 32'h0);
        tick();
        #1;
        checkOutput("resPsel", {28'h0, psel}, 32'h0);
        checkOutput("resData", data, 32'h0);
        checkOutput("resBusy", {31'h0, busy}, 32'h0);
        checkOutput("resPop", {31'h0, fb_pop}, 32'h0);
        res = 1'b0;
        line_start = 1'b0;
        gfx_act = 1'b0;
        tick();
        tick();
        #1;
        checkOutput("resStaysIdle", {31'h0, busy}, 32'h0);

        checkOutput("pixQDrained", pixQ.size(), 32'h0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
